alu_issue_scheduler: RTL and testbench

Slot manager and issue scheduler for the ALU reservation queue. Allocates free queue slots to up to four dispatch lanes per cycle. Tracks occupancy. Each cycle selects one occupied, operand-ready slot by round-robin and presents it to the ALU through a valid/ready handshake. It sits between the dispatch stage and the ALU queue storage. The queue holds operands and does forwarding wake-up; this block owns only slot indices and occupancy.

---
 rtl/alu_issue_scheduler_if.sv | 30 +++
 rtl/alu_issue_scheduler.sv | 125 ++++++++++++
 tb/tb_alu_issue_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_scheduler_if.sv
// Dispatch/issue bundle between the dispatch stage, ALU queue storage and the scheduler.
// The master side drives requests, ready flags and ALU acceptance; the scheduler is the slave.
interface alu_issue_scheduler_if #(
    parameter int QUEUE_SIZE = 16,
    parameter int PTR_W      = 4
);
    logic [3:0]            inValid;
    logic [PTR_W-1:0]      allocSlot0;
    logic [PTR_W-1:0]      allocSlot1;
    logic [PTR_W-1:0]      allocSlot2;
    logic [PTR_W-1:0]      allocSlot3;
    logic                  dispatchStall;
    logic [QUEUE_SIZE-1:0] entryReady;
    logic                  issueValid;
    logic [PTR_W-1:0]      issueSlot;
    logic                  aluReady;
    logic [PTR_W:0]        freeCount;

    modport master (
        output inValid, entryReady, aluReady,
        input  allocSlot0, allocSlot1, allocSlot2, allocSlot3,
        input  dispatchStall, issueValid, issueSlot, freeCount
    );

    modport slave (
        input  inValid, entryReady, aluReady,
        output allocSlot0, allocSlot1, allocSlot2, allocSlot3,
        output dispatchStall, issueValid, issueSlot, freeCount
    );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Slot allocator and round-robin issue selector for the ALU reservation queue.
// Owns only slot occupancy and indices; operands and wake-up live in the queue storage.
module alu_issue_scheduler #(
    parameter int QUEUE_SIZE = 16,
    parameter int PTR_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    alu_issue_scheduler_if.slave bus
);
    localparam int LANES = 4;

    logic [QUEUE_SIZE-1:0] occ;
    logic [PTR_W-1:0]      rrPtr;
    logic                  issueValidR;
    logic [PTR_W-1:0]      issueSlotR;
    logic [PTR_W:0]        freeCountR;

    logic [PTR_W-1:0]      freeSlot [LANES];
    logic [1:0]            laneRank [LANES];
    logic [PTR_W-1:0]      laneSlot [LANES];
    logic [2:0]            reqCount;
    logic [QUEUE_SIZE-1:0] allocMask;
    logic                  accept;

    logic                  handshake;
    logic [QUEUE_SIZE-1:0] issueMask;
    logic [QUEUE_SIZE-1:0] cand;
    logic [PTR_W-1:0]      scanStart;
    logic [PTR_W-1:0]      pick;
    logic                  pickFound;
    logic [PTR_W:0]        freeNext;

    function automatic logic [2:0] popCount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // The four lowest-indexed free slots, taken from registered occupancy only.
    always_comb begin
        logic [2:0] nFound;
        nFound = 3'd0;
        for (int k = 0; k < LANES; k++) freeSlot[k] = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (!occ[i] && nFound < 3'd4) begin
                freeSlot[nFound[1:0]] = PTR_W'(i);
                nFound = nFound + 3'd1;
            end
        end
    end

    // Valid lanes are compacted; an idle lane shows the slot its own lane index would get.
    always_comb begin
        logic [2:0] cnt;
        cnt       = 3'd0;
        allocMask = '0;
        for (int k = 0; k < LANES; k++) begin
            laneRank[k] = bus.inValid[k] ? cnt[1:0] : 2'(k);
            laneSlot[k] = freeSlot[laneRank[k]];
            if (bus.inValid[k]) begin
                allocMask[laneSlot[k]] = 1'b1;
                cnt = cnt + 3'd1;
            end
        end
    end

    assign reqCount = popCount4(bus.inValid);
    assign accept   = ((PTR_W+1)'(reqCount) <= freeCountR) && !flush;

    assign bus.allocSlot0    = laneSlot[0];
    assign bus.allocSlot1    = laneSlot[1];
    assign bus.allocSlot2    = laneSlot[2];
    assign bus.allocSlot3    = laneSlot[3];
    assign bus.dispatchStall = (bus.inValid != 4'b0000) && !accept;

    assign handshake = issueValidR && bus.aluReady && !flush;

    always_comb begin
        issueMask = '0;
        if (issueValidR) issueMask[issueSlotR] = 1'b1;
    end

    assign cand = occ & bus.entryReady & ~issueMask;

    // On a handshake the next pick already starts just past the slot leaving.
    assign scanStart = handshake ? issueSlotR + PTR_W'(1) : rrPtr;

    always_comb begin
        logic [PTR_W-1:0] idx;
        pick      = '0;
        pickFound = 1'b0;
        for (int off = 0; off < QUEUE_SIZE; off++) begin
            idx = scanStart + PTR_W'(off);
            if (!pickFound && cand[idx]) begin
                pickFound = 1'b1;
                pick      = idx;
            end
        end
    end

    assign freeNext = freeCountR + (PTR_W+1)'(handshake)
                    - (accept ? (PTR_W+1)'(reqCount) : '0);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ         <= '0;
            rrPtr       <= '0;
            issueValidR <= 1'b0;
            issueSlotR  <= '0;
            freeCountR  <= (PTR_W+1)'(QUEUE_SIZE);
        end else begin
            occ        <= (occ & ~(handshake ? issueMask : '0)) | (accept ? allocMask : '0);
            freeCountR <= freeNext;
            if (handshake) rrPtr <= issueSlotR + PTR_W'(1);
            if (!issueValidR || handshake) begin
                issueValidR <= pickFound;
                if (pickFound) issueSlotR <= pick;
            end
        end
    end

    assign bus.issueValid = issueValidR;
    assign bus.issueSlot  = issueSlotR;
    assign bus.freeCount  = freeCountR;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler: issue-order scoreboard plus an occupancy model
// that checks allocation, stall and the freeCount invariant every cycle.
module tb_alu_issue_scheduler;
    localparam int QS = 16;
    localparam int PW = 4;

    logic clk;
    logic reset;
    logic flush;

    alu_issue_scheduler_if #(.QUEUE_SIZE(QS), .PTR_W(PW)) bus ();

    alu_issue_scheduler #(.QUEUE_SIZE(QS), .PTR_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [QS-1:0] modelOcc;
    int sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks the current cycle against the model, advances one edge, checks the count.
    task automatic tick();
        logic [3:0]    iv;
        logic [PW-1:0] lane [4];
        logic [PW-1:0] fl [4];
        int            nf;
        int            n;
        int            j;
        logic          acc;
        logic          hs;
        #1;
        iv      = bus.inValid;
        lane[0] = bus.allocSlot0;
        lane[1] = bus.allocSlot1;
        lane[2] = bus.allocSlot2;
        lane[3] = bus.allocSlot3;
        hs = bus.issueValid && bus.aluReady && !flush;
        if (hs) begin
            check("issue_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("issue_order", 32'(bus.issueSlot), 32'(sb.pop_front()));
        end
        n  = $countones(iv);
        nf = 0;
        for (int k = 0; k < 4; k++) fl[k] = '0;
        for (int i = 0; i < QS; i++) begin
            if (!modelOcc[i] && nf < 4) begin
                fl[nf] = PW'(i);
                nf++;
            end
        end
        acc = !flush && (n <= QS - $countones(modelOcc));
        check("stall", 32'(bus.dispatchStall), 32'((iv != 4'b0000) && !acc));
        if (acc) begin
            j = 0;
            for (int k = 0; k < 4; k++) begin
                if (iv[k]) begin
                    check($sformatf("alloc_lane%0d", k), 32'(lane[k]), 32'(fl[j]));
                    j++;
                end
            end
        end
        if (flush) begin
            modelOcc = '0;
        end else begin
            if (hs) modelOcc[bus.issueSlot] = 1'b0;
            if (acc) for (int k = 0; k < n; k++) modelOcc[fl[k]] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("free_invariant", 32'(bus.freeCount), 32'(QS - $countones(modelOcc)));
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        bus.inValid    = 4'b0000;
        bus.entryReady = '0;
        bus.aluReady   = 1'b0;
        modelOcc       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_free", 32'(bus.freeCount), 32'd16);
        check("rst_ivalid", 32'(bus.issueValid), 32'd0);
        check("rst_islot", 32'(bus.issueSlot), 32'd0);
        check("rst_a0", 32'(bus.allocSlot0), 32'd0);
        check("rst_a1", 32'(bus.allocSlot1), 32'd1);
        check("rst_a2", 32'(bus.allocSlot2), 32'd2);
        check("rst_a3", 32'(bus.allocSlot3), 32'd3);
        check("rst_stall", 32'(bus.dispatchStall), 32'd0);

        // Sparse lane set compacts onto slots 0..2.
        bus.inValid = 4'b1011;
        #1;
        check("c_a0", 32'(bus.allocSlot0), 32'd0);
        check("c_a1", 32'(bus.allocSlot1), 32'd1);
        check("c_a3", 32'(bus.allocSlot3), 32'd2);
        check("c_stall", 32'(bus.dispatchStall), 32'd0);
        tick();
        bus.inValid = 4'b0000;
        #1;
        check("c_free13", 32'(bus.freeCount), 32'd13);
        check("c_next_a0", 32'(bus.allocSlot0), 32'd3);

        // Back-to-back issue of 0, 1, 2.
        bus.entryReady = 16'h0007;
        bus.aluReady   = 1'b1;
        sb.push_back(0);
        sb.push_back(1);
        sb.push_back(2);
        repeat (4) tick();
        check("b2b_ivalid_low", 32'(bus.issueValid), 32'd0);
        check("b2b_free16", 32'(bus.freeCount), 32'd16);
        bus.entryReady = '0;
        bus.aluReady   = 1'b0;

        // Fill slots 0..6, offer slot 5 and hold it while slot 6 becomes ready.
        bus.inValid = 4'b1111;
        tick();
        bus.inValid = 4'b0111;
        tick();
        bus.inValid    = 4'b0000;
        bus.entryReady = 16'h0020;
        tick();
        check("hold_ivalid", 32'(bus.issueValid), 32'd1);
        check("hold_islot", 32'(bus.issueSlot), 32'd5);
        bus.entryReady = 16'h0060;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold_stable_slot", 32'(bus.issueSlot), 32'd5);
            check("hold_stable_valid", 32'(bus.issueValid), 32'd1);
        end
        bus.aluReady = 1'b1;
        sb.push_back(5);
        sb.push_back(6);
        tick();
        check("after_hs_slot6", 32'(bus.issueSlot), 32'd6);
        check("after_hs_valid", 32'(bus.issueValid), 32'd1);
        tick();
        check("drain_ivalid_low", 32'(bus.issueValid), 32'd0);
        bus.aluReady   = 1'b0;
        bus.entryReady = '0;

        // Bring occupancy to 14, then request 3 lanes while a slot is freed.
        bus.inValid = 4'b1111;
        tick();
        tick();
        bus.inValid = 4'b0001;
        tick();
        bus.inValid = 4'b0000;
        check("near_full_free2", 32'(bus.freeCount), 32'd2);
        bus.entryReady = 16'h0001;
        tick();
        check("wrap_ivalid", 32'(bus.issueValid), 32'd1);
        check("wrap_islot", 32'(bus.issueSlot), 32'd0);
        bus.inValid    = 4'b0111;
        bus.aluReady   = 1'b1;
        bus.entryReady = '0;
        sb.push_back(0);
        #1;
        check("nobypass_stall", 32'(bus.dispatchStall), 32'd1);
        tick();
        check("nobypass_free3", 32'(bus.freeCount), 32'd3);
        check("nobypass_ivalid", 32'(bus.issueValid), 32'd0);
        bus.aluReady = 1'b0;
        #1;
        check("retry_stall", 32'(bus.dispatchStall), 32'd0);
        check("retry_a0", 32'(bus.allocSlot0), 32'd0);
        check("retry_a1", 32'(bus.allocSlot1), 32'd14);
        check("retry_a2", 32'(bus.allocSlot2), 32'd15);
        tick();
        bus.inValid = 4'b0000;
        check("full_free0", 32'(bus.freeCount), 32'd0);

        // Flush with an offer pending, ALU ready and all lanes requesting.
        bus.entryReady = '1;
        tick();
        check("pre_flush_ivalid", 32'(bus.issueValid), 32'd1);
        check("pre_flush_islot", 32'(bus.issueSlot), 32'd1);
        flush        = 1'b1;
        bus.aluReady = 1'b1;
        bus.inValid  = 4'b1111;
        #1;
        check("flush_stall", 32'(bus.dispatchStall), 32'd1);
        tick();
        flush        = 1'b0;
        bus.aluReady = 1'b0;
        bus.inValid  = 4'b0000;
        #1;
        check("flush_ivalid", 32'(bus.issueValid), 32'd0);
        check("flush_free16", 32'(bus.freeCount), 32'd16);
        check("flush_a0", 32'(bus.allocSlot0), 32'd0);
        check("flush_a1", 32'(bus.allocSlot1), 32'd1);
        check("flush_a2", 32'(bus.allocSlot2), 32'd2);
        check("flush_a3", 32'(bus.allocSlot3), 32'd3);
        tick();
        check("flush_no_issue", 32'(bus.issueValid), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
